// File: rtl/m_wb_uarttx.sv
// Wishbone byte-wide UART transmitter (8N1, LSB first) with a small byte FIFO and baud FSM.
// Latency: ACK_O one cycle after request; usartTX start bit on the edge after the acking edge when idle.
// Backpressure: data writes stall (ACK_O withheld) while the FIFO is full, resuming the edge after a pop.
// Ports: CLK_I clock; RST_I sync active-low reset; CYC_I/STB_I/WE_I/ADR_I/DAT_I Wishbone request
//        (ADR_I 0 = data, 1 = status); DAT_O/ACK_O Wishbone response; usartTX serial out, idle high.
module m_wb_uarttx #(
  parameter int CLKDIV   = 287,
  parameter int FIFOLOG2 = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [7:0]  DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        usartTX
);

  localparam int DEPTH = 1 << FIFOLOG2;
  localparam int CW    = FIFOLOG2 + 1;
  localparam int BW    = $clog2(CLKDIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]          mem [DEPTH];
  logic [FIFOLOG2-1:0] wr_ptr;
  logic [FIFOLOG2-1:0] rd_ptr;
  logic [CW-1:0]       count;
  state_t              state;
  logic [BW-1:0]       baud;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;

  logic        req;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        baud_done;
  logic [31:0] status;

  // Fullness and emptiness come from the registered count only, so a pop
  // frees a slot for a stalled write one edge later, never on the same edge.
  always_comb begin
    req        = CYC_I & STB_I & ~ACK_O;
    fifo_empty = (count == '0);
    fifo_full  = (count == CW'(DEPTH));
    push       = req & WE_I & ~ADR_I & ~fifo_full;
    baud_done  = (baud == '0);
    pop        = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_done));
    status     = {24'd0, 5'(count), (state != IDLE), fifo_full, fifo_empty};
  end

  // Bus response: every request except a data write into a full FIFO is
  // acked on the next edge; DAT_O carries data only alongside a read ack.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= req & ~(WE_I & ~ADR_I & fifo_full);
      DAT_O <= (req & ~WE_I & ADR_I) ? status : '0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= DAT_I;
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Transmit FSM. usartTX is assigned together with each state change so
  // the pin level always matches the bit period the FSM is timing.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state   <= IDLE;
      usartTX <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          usartTX <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            baud    <= BAUD_RELOAD;
            bit_idx <= '0;
            usartTX <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= BAUD_RELOAD;
            usartTX <= shift[0];
            shift   <= shift >> 1;
            state   <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              usartTX <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              usartTX <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (pop) begin
              shift   <= mem[rd_ptr];
              baud    <= BAUD_RELOAD;
              bit_idx <= '0;
              usartTX <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          usartTX <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_wb_uarttx.sv
module tb_m_wb_uarttx;

  localparam int CLKDIV   = 4;
  localparam int FIFOLOG2 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        adr;
  logic [7:0]  dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        tx;

  int tests  = 0;
  int failed = 0;
  int ncyc   = 0;
  logic txlog [0:4095];

  always #5 clk = ~clk;

  m_wb_uarttx #(.CLKDIV(CLKDIV), .FIFOLOG2(FIFOLOG2)) dut (
    .CLK_I   (clk),
    .RST_I   (rst_n),
    .CYC_I   (cyc),
    .STB_I   (stb),
    .WE_I    (we),
    .ADR_I   (adr),
    .DAT_I   (dat_w),
    .DAT_O   (dat_r),
    .ACK_O   (ack),
    .usartTX (tx)
  );

  // ncyc = number of rising edges so far; txlog[n] = pin level after edge n.
  always @(posedge clk) ncyc <= ncyc + 1;
  always @(negedge clk) txlog[ncyc % 4096] = tx;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic a, input logic [7:0] d, output int ack_cyc);
    int n;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 100);
    ack_cyc = ncyc;
    chk("write_ack", 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic a, output logic [31:0] d);
    int n;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 100);
    d = dat_r;
    chk("read_ack", 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Idle-high sample before the start edge, then 10 bit periods of CLKDIV cycles.
  task automatic frame_check(input string tag, input int start, input logic [7:0] d);
    logic [40:0] obs;
    logic [40:0] exp;
    int j;
    for (int i = 0; i < 41; i++) begin
      obs[i] = txlog[(start - 1 + i) % 4096];
      if (i == 0) exp[i] = 1'b1;
      else begin
        j = (i - 1) / CLKDIV;
        if (j == 0)      exp[i] = 1'b0;
        else if (j <= 8) exp[i] = d[j-1];
        else             exp[i] = 1'b1;
      end
    end
    chk(tag, 64'(obs), 64'(exp));
  endtask

  initial begin
    logic [31:0] d;
    int e;
    int e2;
    int a [6];
    int off [6];
    logic [5:0] acks;
    logic [5:0] datv;
    logic [30:0] dathi;
    logic [5:0] txv;
    off = '{0, 2, 4, 6, 8, 42};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; dat_w = 8'h00;
    repeat (3) tick();
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_dat", 64'(dat_r), 64'd0);
    rst_n = 1'b1;
    tick();

    // Status after reset: empty only.
    wb_read(1'b1, d);
    chk("status_reset", 64'(d), 64'h1);
    tick();
    chk("ack_drop", 64'(ack), 64'd0);
    chk("dat_drop", 64'(dat_r), 64'd0);

    // Single byte 0x55.
    wb_write(1'b0, 8'h55, e);
    chk("tx_at_ack", 64'(tx), 64'd1);
    repeat (42) tick();
    frame_check("frame_55", e + 1, 8'h55);
    chk("tx_idle_after_55", 64'(txlog[(e + 41) % 4096]), 64'd1);
    wb_read(1'b1, d);
    chk("status_idle", 64'(d), 64'h1);

    // Two writes: byte 1 in flight, byte 2 queued.
    wb_write(1'b0, 8'h11, e);
    wb_write(1'b0, 8'h22, e2);
    chk("write2_spacing", 64'(e2 - e), 64'd2);
    wb_read(1'b1, d);
    chk("status_busy_cnt1", 64'(d), 64'hC);
    repeat (100) tick();
    frame_check("frame_11", e + 1, 8'h11);
    frame_check("frame_22", e + 41, 8'h22);

    // Six back-to-back writes: one byte goes straight to the shifter, four fill
    // the FIFO, the sixth stalls until the end-of-frame pop.
    for (int k = 0; k < 6; k++) wb_write(1'b0, 8'(k + 1), a[k]);
    for (int k = 1; k < 6; k++) chk($sformatf("b2b_ack_%0d", k), 64'(a[k] - a[0]), 64'(off[k]));
    wb_read(1'b1, d);
    chk("status_full", 64'(d), 64'h26);
    while (ncyc < a[0] + 245) tick();
    for (int k = 0; k < 6; k++)
      frame_check($sformatf("frame_b2b_%0d", k + 1), a[0] + 1 + 40 * k, 8'(k + 1));
    chk("tx_idle_after_b2b", 64'(txlog[(a[0] + 241) % 4096]), 64'd1);

    // Reset during data bit 3 of 0xA5.
    wb_write(1'b0, 8'hA5, e);
    while (ncyc < e + 18) tick();
    chk("tx_bit3_a5", 64'(tx), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("tx_after_abort", 64'(tx), 64'd1);
    chk("ack_after_abort", 64'(ack), 64'd0);
    rst_n = 1'b1;
    tick();
    wb_read(1'b1, d);
    chk("status_after_abort", 64'(d), 64'h1);
    wb_write(1'b0, 8'h3C, e);
    repeat (45) tick();
    frame_check("frame_3c", e + 1, 8'h3C);

    // Write to status address has no effect.
    wb_write(1'b1, 8'hFF, e);
    wb_read(1'b1, d);
    chk("status_after_adr1_write", 64'(d), 64'h1);
    repeat (5) tick();
    for (int i = 0; i < 6; i++) txv[i] = txlog[(e + i) % 4096];
    chk("tx_quiet_adr1", 64'(txv), 64'h3F);

    // Continuous strobe: one ack per access, DAT_O zero between acks.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b1;
    dathi = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks[i] = ack;
      datv[i] = dat_r[0];
      dathi   = dathi | dat_r[31:1];
    end
    chk("held_stb_acks", 64'(acks), 64'h15);
    chk("held_stb_dat0", 64'(datv), 64'h15);
    chk("held_stb_dathi", 64'(dathi), 64'd0);
    adr = 1'b0;
    tick();
    chk("read_adr0_ack", 64'(ack), 64'd1);
    chk("read_adr0_dat", 64'(dat_r), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
